// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer, the control unit and the PC mux.
package pc_sequencer_pkg;

   localparam logic [2:0] PCSRC_INC    = 3'b000;
   localparam logic [2:0] PCSRC_BRANCH = 3'b001;
   localparam logic [2:0] PCSRC_JUMP   = 3'b010;
   localparam logic [2:0] PCSRC_JR     = 3'b011;
   localparam logic [2:0] PCSRC_EXC    = 3'b100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

   function automatic logic word_aligned(input logic [31:0] a);
      return (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_mux5.sv
// Five-input next-PC mux driven by the pc_src select code.
module pc_mux5
   import pc_sequencer_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [31:0] in_inc,
   input  logic [31:0] in_branch,
   input  logic [31:0] in_jump,
   input  logic [31:0] in_jr,
   input  logic [31:0] in_exc,
   output logic [31:0] out
);

   always_comb begin
      out = in_inc;
      case (sel)
         PCSRC_BRANCH: out = in_branch;
         PCSRC_JUMP:   out = in_jump;
         PCSRC_JR:     out = in_jr;
         PCSRC_EXC:    out = in_exc;
         default:      out = in_inc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer_pc_src_encoder.sv
// Priority encoder for redirect requests with target alignment check.
module pc_src_encoder
   import pc_sequencer_pkg::*;
(
   input  logic        exception,
   input  logic        jr,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic [31:0] jr_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] branch_target,
   output logic [2:0]  pc_src,
   output logic        misalign_hit
);

   logic [2:0] code;
   logic       ok;

   always_comb begin
      code = PCSRC_INC;
      ok   = 1'b1;
      if (exception) begin
         code = PCSRC_EXC;
      end else if (jr) begin
         code = PCSRC_JR;
         ok   = word_aligned(jr_target);
      end else if (jump) begin
         code = PCSRC_JUMP;
         ok   = word_aligned(jump_target);
      end else if (branch_taken) begin
         code = PCSRC_BRANCH;
         ok   = word_aligned(branch_target);
      end
   end

   // A misaligned redirect traps instead of fetching from a bad address
   assign misalign_hit = ~ok;
   assign pc_src       = ok ? code : PCSRC_EXC;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch handshake sequencer.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        exception,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [2:0]  pc_src,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        misalign
);

   logic [1:0]  state;
   logic        advance;
   logic [2:0]  enc_src;
   logic        enc_mis;
   logic [31:0] next_pc;

   assign advance   = (state == ST_HOLD) & ~stall;
   assign pc_src    = advance ? enc_src : PCSRC_INC;
   assign imem_req  = (state == ST_REQ);
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

   pc_src_encoder u_enc (
      .exception     (exception),
      .jr            (jr),
      .jump          (jump),
      .branch_taken  (branch_taken),
      .jr_target     (jr_target),
      .jump_target   (jump_target),
      .branch_target (branch_target),
      .pc_src        (enc_src),
      .misalign_hit  (enc_mis)
   );

   pc_mux5 u_mux (
      .sel       (pc_src),
      .in_inc    (pc_plus4),
      .in_branch (branch_target),
      .in_jump   (jump_target),
      .in_jr     (jr_target),
      .in_exc    (EXC_VECTOR),
      .out       (next_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         instr       <= 32'd0;
         instr_valid <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         misalign <= 1'b0;
         unique case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  misalign    <= enc_mis;
                  state       <= ST_REQ;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        jr;
   logic [31:0] jr_target;
   logic        exception;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [2:0]  pc_src;
   logic [31:0] instr;
   logic        instr_valid;
   logic        misalign;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_pc;

   pc_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .jr            (jr),
      .jr_target     (jr_target),
      .exception     (exception),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .pc_src        (pc_src),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .misalign      (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: priority and alignment rules stated directly
   function automatic void model_next(
      input bit e, input bit r, input bit j, input bit b,
      input bit [31:0] rt, input bit [31:0] jt, input bit [31:0] bt,
      input bit [31:0] cur,
      output bit [2:0] src, output bit [31:0] npc, output bit mis);
      bit [31:0] t;
      bit redirect;
      redirect = 1;
      mis = 0;
      if (e) begin src = 4; t = 32'h80; redirect = 0; end
      else if (r) begin src = 3; t = rt; end
      else if (j) begin src = 2; t = jt; end
      else if (b) begin src = 1; t = bt; end
      else begin src = 0; t = cur + 4; redirect = 0; end
      if (redirect && (t % 4) != 0) begin
         src = 4; t = 32'h80; mis = 1;
      end
      npc = t;
   endfunction

   task automatic clear_req();
      exception    = 0;
      jr           = 0;
      jump         = 0;
      branch_taken = 0;
   endtask

   task automatic fetch(input int lat, input logic [31:0] data);
      for (int k = 0; k < lat; k++) @(negedge clk);
      imem_ack   = 1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack   = 0;
      imem_rdata = $urandom;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_regs pc=%h instr=%h v=%b want 0/0/0",
                  pc, instr, instr_valid);
      end
      n_checks++;
      if (imem_req !== 1'b0 || misalign !== 1'b0 || pc_src !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outs req=%b mis=%b src=%b want 0/0/000",
                  imem_req, misalign, pc_src);
      end
   endtask

   task automatic test_first_fetch();
      logic [31:0] d;
      d = 32'hDEAD_0013;
      @(negedge clk);
      rst_n = 1;
      #1;
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_req got=%b want=0", imem_req);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL req_hold%0d req=%b addr=%h want 1/0", k,
                     imem_req, imem_addr);
         end
         if (k == 0) @(negedge clk);
      end
      fetch(0, d);
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== d || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL first_ack v=%b instr=%h req=%b want 1/%h/0",
                  instr_valid, instr, imem_req, d);
      end
      n_checks++;
      if (pc_src !== 3'b000) begin
         n_fail++;
         $display("FAIL first_src got=%b want=000", pc_src);
      end
      @(negedge clk);
      n_checks++;
      if (pc !== 32'h4 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL first_adv pc=%h v=%b req=%b want 4/0/1",
                  pc, instr_valid, imem_req);
      end
   endtask

   task automatic test_priority();
      fetch(1, 32'h1111_1111);
      branch_taken = 1; branch_target = 32'h40;
      jump = 1; jump_target = 32'h100;
      #1;
      n_checks++;
      if (pc_src !== 3'b010) begin
         n_fail++;
         $display("FAIL jmp_over_br src=%b want=010", pc_src);
      end
      @(negedge clk);
      clear_req();
      n_checks++;
      if (pc !== 32'h100) begin
         n_fail++;
         $display("FAIL jmp_over_br_pc got=%h want=100", pc);
      end
      fetch(2, 32'h2222_2222);
      exception = 1; jr = 1; jr_target = 32'h200;
      jump = 1; branch_taken = 1;
      #1;
      n_checks++;
      if (pc_src !== 3'b100) begin
         n_fail++;
         $display("FAIL exc_all src=%b want=100", pc_src);
      end
      @(negedge clk);
      clear_req();
      n_checks++;
      if (pc !== 32'h80 || misalign !== 1'b0) begin
         n_fail++;
         $display("FAIL exc_pc pc=%h mis=%b want 80/0", pc, misalign);
      end
      fetch(0, 32'h3333_3333);
      jr = 1; jr_target = 32'h200; jump = 1; jump_target = 32'h500;
      #1;
      n_checks++;
      if (pc_src !== 3'b011) begin
         n_fail++;
         $display("FAIL jr_over_jmp src=%b want=011", pc_src);
      end
      @(negedge clk);
      clear_req();
      n_checks++;
      if (pc !== 32'h200) begin
         n_fail++;
         $display("FAIL jr_pc got=%h want=200", pc);
      end
   endtask

   task automatic test_misalign();
      fetch(1, 32'h4444_4444);
      jr = 1; jr_target = 32'h0000_0102;
      #1;
      n_checks++;
      if (pc_src !== 3'b100) begin
         n_fail++;
         $display("FAIL mis_src got=%b want=100", pc_src);
      end
      @(negedge clk);
      clear_req();
      n_checks++;
      if (pc !== 32'h80 || misalign !== 1'b1) begin
         n_fail++;
         $display("FAIL mis_pulse pc=%h mis=%b want 80/1", pc, misalign);
      end
      @(negedge clk);
      n_checks++;
      if (misalign !== 1'b0) begin
         n_fail++;
         $display("FAIL mis_one_cycle got=%b want=0", misalign);
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      fetch(1, 32'h5555_5555);
      held = pc;
      stall = 1; jump = 1; jump_target = 32'h300;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (pc_src !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_src%0d got=%b want=000", k, pc_src);
         end
         @(negedge clk);
         n_checks++;
         if (pc !== held || instr_valid !== 1'b1 || instr !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL stall_hold%0d pc=%h v=%b want %h/1", k,
                     pc, instr_valid, held);
         end
      end
      stall = 0;
      #1;
      n_checks++;
      if (pc_src !== 3'b010) begin
         n_fail++;
         $display("FAIL unstall_src got=%b want=010", pc_src);
      end
      @(negedge clk);
      clear_req();
      n_checks++;
      if (pc !== 32'h300) begin
         n_fail++;
         $display("FAIL unstall_pc got=%h want=300", pc);
      end
   endtask

   task automatic test_reset_mid_req();
      @(negedge clk);
      #2;
      rst_n    = 0;
      imem_ack = 1;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid req=%b pc=%h v=%b want 0/0/0",
                  imem_req, pc, instr_valid);
      end
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ack_ignored v=%b want=0", instr_valid);
      end
      rst_n    = 1;
      imem_ack = 0;
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_refetch req=%b addr=%h want 1/0",
                  imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      fetch(0, 32'h6666_6666);
      jump = 1; jump_target = 32'hFFFF_FFFC;
      @(negedge clk);
      clear_req();
      fetch(1, 32'h7777_7777);
      n_checks++;
      if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_plus4 pc=%h p4=%h want fffffffc/0",
                  pc, pc_plus4);
      end
      @(negedge clk);
      n_checks++;
      if (pc !== 32'h0 || misalign !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_pc pc=%h mis=%b want 0/0", pc, misalign);
      end
   endtask

   task automatic test_random();
      bit [2:0]  esrc;
      bit [31:0] enpc;
      bit        emis;
      logic [31:0] d;
      int ns;
      exp_pc = 32'h0;
      for (int it = 0; it < 60; it++) begin
         d = $urandom;
         fetch($urandom_range(0, 3), d);
         n_checks++;
         if (instr !== d || instr_valid !== 1'b1 || pc !== exp_pc ||
             pc_plus4 !== exp_pc + 32'd4 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_fetch%0d pc=%h instr=%h v=%b want %h/%h/1",
                     it, pc, instr, instr_valid, exp_pc, d);
         end
         exception    = ($urandom_range(0, 5) == 0);
         jr           = ($urandom_range(0, 3) == 0);
         jump         = ($urandom_range(0, 2) == 0);
         branch_taken = ($urandom_range(0, 1) == 0);
         jr_target     = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         jump_target   = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         branch_target = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         ns = $urandom_range(0, 2);
         stall = (ns > 0);
         for (int k = 0; k < ns; k++) begin
            #1;
            n_checks++;
            if (pc_src !== 3'b000) begin
               n_fail++;
               $display("FAIL rnd_stall_src%0d got=%b want=000", it, pc_src);
            end
            @(negedge clk);
            n_checks++;
            if (pc !== exp_pc) begin
               n_fail++;
               $display("FAIL rnd_stall_pc%0d got=%h want=%h", it, pc, exp_pc);
            end
         end
         stall = 0;
         model_next(exception, jr, jump, branch_taken, jr_target,
                    jump_target, branch_target, exp_pc, esrc, enpc, emis);
         #1;
         n_checks++;
         if (pc_src !== esrc) begin
            n_fail++;
            $display("FAIL rnd_src%0d got=%b want=%b", it, pc_src, esrc);
         end
         @(negedge clk);
         clear_req();
         n_checks++;
         if (pc !== enpc || misalign !== emis || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_adv%0d pc=%h mis=%b v=%b want %h/%b/0",
                     it, pc, misalign, instr_valid, enpc, emis);
         end
         exp_pc = enpc;
      end
   endtask

   initial begin
      stall         = 0;
      imem_ack      = 0;
      imem_rdata    = 0;
      branch_target = 0;
      jump_target   = 0;
      jr_target     = 0;
      clear_req();
      test_reset();
      test_first_fetch();
      test_priority();
      test_misalign();
      test_stall();
      test_reset_mid_req();
      test_wrap();
      test_reset();
      test_first_fetch();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and generates the 3-bit next-PC source select that the 5-input PC mux consumes.
- Runs the instruction-fetch handshake with instruction memory.
- Resolves competing redirect requests (exception, jr, jump, branch) into a single select code, then registers the chosen next PC.
- Sits between the control unit/branch logic and instruction memory at the front of the datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, exception handler address; this is the source-100 value.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hazard hold; blocks PC advance
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  32  branch destination
- jump  input  1  j/jal
- jump_target  input  32  jump destination
- jr  input  1  jump-register
- jr_target  input  32  register destination
- exception  input  1  trap request
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address, equal to pc
- imem_ack  input  1  memory returns data this cycle
- imem_rdata  input  32  fetched instruction
- pc  output  32  current PC
- pc_plus4  output  32  pc + 4
- pc_src  output  3  select code: 000 inc, 001 branch, 010 jump, 011 jr, 100 exception
- instr  output  32  registered instruction
- instr_valid  output  1  instr holds the fetch for the current pc
- misalign  output  1  one-cycle pulse: a redirect target was not word aligned

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign=0.
  - A reset asserted mid-request drops imem_req immediately; the returning ack is ignored.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - Lasts exactly one cycle after reset deassertion, then goes to REQ.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, go to HOLD.
  - Without ack, stay in REQ with addr stable.
  - Zero-wait memory (ack in the same cycle as req) is legal.
- HOLD:
  - imem_req=0.
  - If stall=1: stay in HOLD; pc, instr and instr_valid unchanged.
  - If stall=0: pc<=selected next PC, instr_valid<=0, go to REQ.
- Minimum throughput is 2 cycles per instruction.
- Next-PC selection is combinational and valid only in HOLD. Priority is exception > jr > jump > branch_taken > increment.
  - pc_src is the matching code for the winning request.
  - pc_src=000 in IDLE/REQ and during stall.
  - The select inputs and targets are ignored outside HOLD or while stalled. The control unit holds them until the advance.
- Misalignment:
  - If the winning target of jr, jump or branch has bits[1:0]!=0, pc_src becomes 100 and the next PC is EXC_VECTOR.
  - misalign pulses for one cycle, registered on the advancing edge.
- Arithmetic: pc_plus4 = pc+4 modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal and silent.
- Simultaneous requests: all asserted together resolve to 100. jr+jump resolves to 011. jump+branch resolves to 010.

Decomposition:
- Shared package holds:
  - pc_src localparams (PCSRC_INC, PCSRC_BRANCH, PCSRC_JUMP, PCSRC_JR, PCSRC_EXC).
  - FSM state encodings.
  - Default EXC_VECTOR.
  - The same constants feed the control unit and the PC mux instantiation.
- One sub-module is natural: pc_src_encoder, the combinational priority encoder plus alignment check (inputs: request flags and targets; outputs: pc_src, misalign_hit).
- The sequencer instantiates the existing 5-input PC mux for the next-PC value rather than duplicating it.

Test Plan:
- Reset release, memory acks 2 cycles after req → imem_addr=0 held through REQ; instr_valid=1 after ack; advance gives pc=4, pc_src=000.
- HOLD with branch_taken=1, branch_target=32'h40, jump=1, jump_target=32'h100 → pc_src=010, next pc=32'h100.
- HOLD with exception=1, jr=1 → pc_src=100, next pc=32'h80, misalign=0.
- jr_target=32'h0000_0102 → pc_src=100, next pc=32'h80, misalign pulses once.
- stall=1 for 3 cycles in HOLD with jump asserted → pc unchanged, pc_src=000; stall drop → pc=jump_target the following cycle.
- rst_n low while in REQ awaiting ack → imem_req=0 immediately; after release, the first request is to 32'h0; pc=32'hFFFF_FFFC advancing gives pc=0.
